ae350_clk_rst_seq: RTL
======================

// Module: ae350_clk_rst_seq
// PURPOSE
//  Sits directly downstream of the AE350 PLL wrapper and runs in the 50 MHz PLL reference clock domain (clkin).
//  Qualifies PLL lock, then turns on the PLL output clock enables one at a time.
//  Then releases the core reset request, and tears everything down again when lock is lost.
//  Gives the SoC a deterministic clock/reset bring-up sequence and a lock-loss recovery path.
// PARAMETERS
//  NUM_CLK            5      number of enclk outputs (PLL ENCLK0..4); range 1..7
//  LOCK_STABLE_CYCLES 1024   consecutive synced-lock cycles required before clock enable
//  ENCLK_GAP          16     cycles between successive enclk[i] assertions; >=1
//  RST_DELAY          64     cycles from RST_REL entry to core_rstn release; >=1
//  LOCK_TIMEOUT       65536  WAIT_LOCK cycles before PLL reset retry (macro builds only)
//  PLL_RST_CYCLES     32     pll_reset pulse width (macro builds only); >=1
//  CNT_W              17     shared down/up counter width; must hold max of all counts above
// PORTS
//  clkin          in   1        PLL reference clock; the only clock in the block
//  rstn           in   1        asynchronous assert, active-low reset (power-on / board reset)
//  lock           in   1        PLL lock; asynchronous to clkin; synchronized internally
//  enclk          out  NUM_CLK  PLL ENCLKn drives; bit i drives ENCLKi
//  pll_reset      out  1        PLL RESET drive; constant 0 when the macro is not defined
//  core_rstn      out  1        active-low reset request to downstream reset synchronizers
//  ready          out  1        1 only in RUN
//  seq_state      out  3        current state (encoding below)
//  lock_loss_cnt  out  8        count of lock losses after qualification; saturates at 255
// BEHAVIOUR
//  Reset state: rstn=0 forces the following values asynchronously.
//   - enclk=0, pll_reset=0, core_rstn=0, ready=0, lock_loss_cnt=0.
//   - State is WAIT_LOCK; all counters are 0.
//  All outputs are registered.
//  Lock synchronizer: lock -> lock_s through a 2-flop synchronizer, giving 2 clkin cycles of latency.
//  State encoding: WAIT_LOCK=0, EN_CLK=1, RST_REL=2, RUN=3, PLL_RST=4.
//  WAIT_LOCK
//   - Counts consecutive lock_s=1 cycles; lock_s=0 clears the count. lock_loss_cnt does not change.
//   - When the count reaches LOCK_STABLE_CYCLES: go to EN_CLK and set enclk[0]=1 on the same edge.
//  EN_CLK
//   - enclk[i] rises i*ENCLK_GAP cycles after enclk[0]. Enables are never cleared while in EN_CLK.
//   - ENCLK_GAP cycles after enclk[NUM_CLK-1] rises: go to RST_REL.
//  RST_REL
//   - After RST_DELAY cycles: core_rstn=1 and ready=1 on the same edge; go to RUN.
//  RUN
//   - Holds all outputs until lock loss.
//  Lock loss: lock_s=0 for any single cycle in EN_CLK, RST_REL or RUN. On the next edge:
//   - enclk=0, core_rstn=0, ready=0.
//   - lock_loss_cnt increments, saturating at 255.
//   - State goes to WAIT_LOCK with counters cleared.
//   - Lock loss takes priority over every other transition in the same cycle.
//  Simultaneous lock loss and a count terminal value: lock loss wins; no further enclk bit is set.
//  rstn asserted mid-sequence: returns to the reset state immediately, lock_loss_cnt included.
//  Counters never wrap. Each counter clears on every state entry.
// CONFIGURATION
//  Macro: AE350_CLKSEQ_PLL_RETRY_EN
//  Defined:
//   - A timeout counter runs in WAIT_LOCK from state entry and is NOT cleared by lock_s glitches.
//   - At LOCK_TIMEOUT: go to PLL_RST, where pll_reset=1 for PLL_RST_CYCLES.
//   - Then pll_reset=0 and the state returns to WAIT_LOCK with both counters cleared.
//   - lock_s is ignored in PLL_RST. lock_loss_cnt does not change.
//  Undefined:
//   - No timeout counter and no PLL_RST state; pll_reset is tied to 0.
//   - WAIT_LOCK waits indefinitely.
// STRUCTURE
//  Package ae350_clkseq_pkg holds:
//   - The seq_state_t enum (3-bit encoding above).
//   - The LOCK_LOSS_CNT_W=8 constant.
//  Sub-module ae350_sync_2ff: a generic 2-flop synchronizer with asynchronous active-low reset, used for lock.
//  The top level contains the FSM, one shared phase counter, the optional timeout counter and the enclk shift register.
// TESTING (bench params: LOCK_STABLE_CYCLES=8, ENCLK_GAP=4, RST_DELAY=6, NUM_CLK=5, LOCK_TIMEOUT=100, PLL_RST_CYCLES=5;
//          cycle 0 = first cycle with lock_s=1)
//  1. Bring-up: rstn release, then lock held at 1.
//     -> enclk[0] at cycle 8, enclk[4] at cycle 24; core_rstn=1, ready=1 at cycle 34; seq_state=3.
//  2. Lock glitch in WAIT_LOCK: lock low for 3 cycles at lock_s cycle 5.
//     -> count restarts; enclk[0] rises 8 cycles after lock_s returns; lock_loss_cnt=0.
//  3. Lock drop in RUN for 1 cycle.
//     -> next edge: enclk=0, core_rstn=0, ready=0, lock_loss_cnt=1; full resequence follows.
//  4. 256 lock drops in RUN.
//     -> lock_loss_cnt stops at 255.
//  5. rstn asserted in EN_CLK with enclk=5'b00011.
//     -> all outputs return to reset values without waiting for a clkin edge.
//  6. Macro defined, lock tied 0.
//     -> pll_reset=1 for cycles 100..104 after rstn release, then repeats every 105 cycles.
//     Macro undefined: pll_reset stays 0.

Source files
------------

// File: rtl/ae350_clkseq_pkg.sv
// Shared types and constants for the AE350 clock/reset bring-up sequencer.
package ae350_clkseq_pkg;

    localparam int LOCK_LOSS_CNT_W = 8;

    typedef enum logic [2:0] {
        ST_WAIT_LOCK = 3'd0,
        ST_EN_CLK    = 3'd1,
        ST_RST_REL   = 3'd2,
        ST_RUN       = 3'd3,
        ST_PLL_RST   = 3'd4
    } seq_state_t;

endpackage

// File: rtl/ae350_sync_2ff.sv
// Generic two-flop synchronizer with asynchronous active-low reset; output
// follows the input with two clock cycles of latency.
module ae350_sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_reg;
    logic [WIDTH-1:0] sync_reg;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            meta_reg <= '0;
            sync_reg <= '0;
        end else begin
            meta_reg <= d;
            sync_reg <= meta_reg;
        end
    end

    assign q = sync_reg;

endmodule

// File: rtl/ae350_clk_rst_seq.sv
// PLL lock qualification, staggered ENCLK enables and core reset release with
// lock-loss teardown. AE350_CLKSEQ_PLL_RETRY_EN adds a WAIT_LOCK timeout that pulses pll_reset.
module ae350_clk_rst_seq
    import ae350_clkseq_pkg::*;
#(
    parameter int NUM_CLK            = 5,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int ENCLK_GAP          = 16,
    parameter int RST_DELAY          = 64,
    parameter int LOCK_TIMEOUT       = 65536,
    parameter int PLL_RST_CYCLES     = 32,
    parameter int CNT_W              = 17
) (
    input  logic                       clkin,
    input  logic                       rstn,
    input  logic                       lock,
    output logic [NUM_CLK-1:0]         enclk,
    output logic                       pll_reset,
    output logic                       core_rstn,
    output logic                       ready,
    output logic [2:0]                 seq_state,
    output logic [LOCK_LOSS_CNT_W-1:0] lock_loss_cnt
);

    localparam logic [CNT_W-1:0] LOCK_TERM = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_TERM  = CNT_W'(ENCLK_GAP - 1);
    localparam logic [CNT_W-1:0] RST_TERM  = CNT_W'(RST_DELAY - 1);

    // Every terminal count must be representable in the shared counter width.
    localparam bit CFG_OK = (NUM_CLK >= 1) && (NUM_CLK <= 7)
                         && (ENCLK_GAP >= 1) && (RST_DELAY >= 1) && (PLL_RST_CYCLES >= 1)
                         && (LOCK_STABLE_CYCLES >= 1) && (LOCK_TIMEOUT >= 1)
                         && (LOCK_STABLE_CYCLES <= (1 << CNT_W)) && (ENCLK_GAP <= (1 << CNT_W))
                         && (RST_DELAY <= (1 << CNT_W)) && (LOCK_TIMEOUT <= (1 << CNT_W))
                         && (PLL_RST_CYCLES <= (1 << CNT_W));

    if (!CFG_OK) begin : g_cfg_error
        $error("ae350_clk_rst_seq: illegal parameter combination");
    end

    seq_state_t                 state_reg;
    logic [CNT_W-1:0]           cnt_reg;
    logic [NUM_CLK-1:0]         enclk_reg;
    logic                       core_rstn_reg;
    logic                       ready_reg;
    logic [LOCK_LOSS_CNT_W-1:0] loss_cnt_reg;
    logic                       lock_s;
    logic                       lock_lost;

`ifdef AE350_CLKSEQ_PLL_RETRY_EN
    localparam logic [CNT_W-1:0] TMO_TERM = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] PRC_TERM = CNT_W'(PLL_RST_CYCLES - 1);
    logic [CNT_W-1:0] tmo_cnt_reg;
    logic             pll_reset_reg;
`endif

    ae350_sync_2ff #(.WIDTH(1)) u_lock_sync (
        .clk  (clkin),
        .rstn (rstn),
        .d    (lock),
        .q    (lock_s)
    );

    // Lock loss only matters once lock has been qualified; PLL_RST ignores lock_s.
    assign lock_lost = !lock_s && ((state_reg == ST_EN_CLK) || (state_reg == ST_RST_REL)
                                   || (state_reg == ST_RUN));

    always_ff @(posedge clkin or negedge rstn) begin
        if (!rstn) begin
            state_reg     <= ST_WAIT_LOCK;
            cnt_reg       <= '0;
            enclk_reg     <= '0;
            core_rstn_reg <= 1'b0;
            ready_reg     <= 1'b0;
            loss_cnt_reg  <= '0;
`ifdef AE350_CLKSEQ_PLL_RETRY_EN
            tmo_cnt_reg   <= '0;
            pll_reset_reg <= 1'b0;
`endif
        end else if (lock_lost) begin
            state_reg     <= ST_WAIT_LOCK;
            cnt_reg       <= '0;
            enclk_reg     <= '0;
            core_rstn_reg <= 1'b0;
            ready_reg     <= 1'b0;
            if (loss_cnt_reg != '1) begin
                loss_cnt_reg <= loss_cnt_reg + LOCK_LOSS_CNT_W'(1);
            end
`ifdef AE350_CLKSEQ_PLL_RETRY_EN
            tmo_cnt_reg   <= '0;
`endif
        end else begin
            case (state_reg)
                ST_WAIT_LOCK: begin
                    if (lock_s && (cnt_reg == LOCK_TERM)) begin
                        state_reg <= ST_EN_CLK;
                        cnt_reg   <= '0;
                        enclk_reg <= NUM_CLK'(1);
`ifdef AE350_CLKSEQ_PLL_RETRY_EN
                        tmo_cnt_reg <= '0;
                    end else if (tmo_cnt_reg == TMO_TERM) begin
                        state_reg     <= ST_PLL_RST;
                        cnt_reg       <= '0;
                        tmo_cnt_reg   <= '0;
                        pll_reset_reg <= 1'b1;
`endif
                    end else begin
                        cnt_reg <= lock_s ? (cnt_reg + CNT_W'(1)) : '0;
`ifdef AE350_CLKSEQ_PLL_RETRY_EN
                        // Timeout keeps running across lock_s glitches.
                        tmo_cnt_reg <= tmo_cnt_reg + CNT_W'(1);
`endif
                    end
                end
                ST_EN_CLK: begin
                    if (cnt_reg == GAP_TERM) begin
                        cnt_reg <= '0;
                        if (enclk_reg[NUM_CLK-1]) begin
                            state_reg <= ST_RST_REL;
                        end else begin
                            enclk_reg <= (enclk_reg << 1) | NUM_CLK'(1);
                        end
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                ST_RST_REL: begin
                    if (cnt_reg == RST_TERM) begin
                        state_reg     <= ST_RUN;
                        cnt_reg       <= '0;
                        core_rstn_reg <= 1'b1;
                        ready_reg     <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                ST_RUN: begin
                    cnt_reg <= '0;
                end
`ifdef AE350_CLKSEQ_PLL_RETRY_EN
                ST_PLL_RST: begin
                    if (cnt_reg == PRC_TERM) begin
                        state_reg     <= ST_WAIT_LOCK;
                        cnt_reg       <= '0;
                        tmo_cnt_reg   <= '0;
                        pll_reset_reg <= 1'b0;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
`endif
                default: begin
                    state_reg <= ST_WAIT_LOCK;
                    cnt_reg   <= '0;
                end
            endcase
        end
    end

    assign enclk         = enclk_reg;
    assign core_rstn     = core_rstn_reg;
    assign ready         = ready_reg;
    assign seq_state     = state_reg;
    assign lock_loss_cnt = loss_cnt_reg;

`ifdef AE350_CLKSEQ_PLL_RETRY_EN
    assign pll_reset = pll_reset_reg;
`else
    assign pll_reset = 1'b0;
`endif

endmodule
